// File: rtl/chk_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : chk_fifo_pkg
// Description : Shared types and helpers for the parity-checking FIFO.
//               Check-mode encoding, width helpers and the parity test.
// Revision    : 1.0 - initial release
// ============================================================================
package chk_fifo_pkg;

  // How the output side treats a word whose parity is wrong.
  typedef enum logic [1:0] {
    CHK_NONE = 2'd0,
    CHK_DROP = 2'd1,
    CHK_FLAG = 2'd2
  } check_mode_e;

  // Widest word parity_ok accepts; narrower words are zero-extended,
  // which leaves their XOR reduction unchanged.
  localparam int PARITY_MAX_W = 1024;

  // Fill-level counter must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Pointer indexes 0..depth-1; never narrower than one bit.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // True when the XOR of every bit of the word equals the selected sense.
  function automatic logic parity_ok(input logic [PARITY_MAX_W-1:0] word,
                                     input logic                    even_odd);
    return (^word) == even_odd;
  endfunction

endpackage
`default_nettype wire

// File: rtl/chk_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : chk_fifo_if
// Description : Push/pop handshake bundle between producer, FIFO and consumer.
//               Signal suffixes are written from the FIFO's point of view.
// Revision    : 1.0 - initial release
// ============================================================================
interface chk_fifo_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH:0] push_data_i;
  logic                push_valid_i;
  logic                push_grant_o;
  logic                pop_grant_i;
  logic [DATA_WIDTH:0] pop_data_o;
  logic                pop_valid_o;
  logic                pop_err_o;

  // FIFO side
  modport slave (
    input  push_data_i, push_valid_i, pop_grant_i,
    output push_grant_o, pop_data_o, pop_valid_o, pop_err_o
  );

  // Producer/consumer side
  modport master (
    output push_data_i, push_valid_i, pop_grant_i,
    input  push_grant_o, pop_data_o, pop_valid_o, pop_err_o
  );
endinterface
`default_nettype wire

// File: rtl/chk_fifo_ram.sv
`default_nettype none
// ============================================================================
// Module      : chk_fifo_ram
// Description : DEPTH x WIDTH register array, one synchronous write port and
//               one asynchronous read port. Contents are never reset.
// Revision    : 1.0 - initial release
// ============================================================================
module chk_fifo_ram #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] memory [DEPTH];

  // Write the pushed word into its slot.
  always_ff @(posedge clk) begin
    if (we_i) begin
      memory[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = memory[raddr_i];

endmodule
`default_nettype wire

// File: rtl/chk_fifo.sv
`default_nettype none
// ============================================================================
// Module      : chk_fifo
// Description : Single-clock first-word-fall-through FIFO of arbitrary depth
//               with output-side parity checking (pass / drop / flag),
//               fill-level thresholds, synchronous flush and a saturating
//               parity-error counter.
// Revision    : 1.0 - initial release
// ============================================================================
module chk_fifo
  import chk_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int EVEN_ODD   = 0,
  parameter int CHECK_MODE = 1,
  parameter int AF_LEVEL   = FIFO_DEPTH - 1,
  parameter int AE_LEVEL   = 1,
  parameter int ERR_W      = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush_i,
  chk_fifo_if.slave                           bus,
  output logic [cnt_width(FIFO_DEPTH)-1:0]    count_o,
  output logic                                almost_full_o,
  output logic                                almost_empty_o,
  output logic [ERR_W-1:0]                    err_cnt_o
);

  localparam int          CW       = cnt_width(FIFO_DEPTH);
  localparam int          PW       = ptr_width(FIFO_DEPTH);
  localparam check_mode_e MODE     = check_mode_e'(CHECK_MODE);
  localparam logic [PW-1:0] LAST_IDX = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             af_q, af_d;
  logic             ae_q, ae_d;

  logic [DATA_WIDTH:0] head;
  logic                not_empty;
  logic                head_bad;
  logic                push_fire;
  logic                pop_fire;
  logic                drop;
  logic                remove;
  logic                err_inc;

  chk_fifo_ram #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH),
    .AW    (PW)
  ) my_ram (
    .clk     (clk),
    .we_i    (push_fire),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.push_data_i),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

  assign not_empty = (count_q != '0);
  assign head_bad  = !parity_ok(PARITY_MAX_W'(head), 1'(EVEN_ODD));

  // Full FIFO never accepts, even with a simultaneous pop.
  assign bus.push_grant_o = !rst && !flush_i && (count_q < DEPTH_C);
  assign bus.pop_data_o   = head;
  assign push_fire        = bus.push_valid_i && bus.push_grant_o;
  assign pop_fire         = bus.pop_valid_o && bus.pop_grant_i;
  assign remove           = pop_fire || drop;

  if (MODE == CHK_DROP) begin : g_drop
    // Corrupt heads are hidden from the consumer and discarded one per cycle.
    assign bus.pop_valid_o = not_empty && !head_bad;
    assign bus.pop_err_o   = 1'b0;
    assign drop            = not_empty && head_bad;
    assign err_inc         = drop;
  end else if (MODE == CHK_FLAG) begin : g_flag
    // Corrupt heads are delivered with an error marker.
    assign bus.pop_valid_o = not_empty;
    assign bus.pop_err_o   = not_empty && head_bad;
    assign drop            = 1'b0;
    assign err_inc         = pop_fire && head_bad;
  end else begin : g_none
    assign bus.pop_valid_o = not_empty;
    assign bus.pop_err_o   = 1'b0;
    assign drop            = 1'b0;
    assign err_inc         = 1'b0;
  end

  // Next-state for pointers, fill level, thresholds and error counter.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    err_cnt_d = err_cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_fire) begin
        wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;
      end
      if (remove) begin
        rd_ptr_d = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + 1'b1;
      end
      if (push_fire && !remove) begin
        count_d = count_q + 1'b1;
      end else if (!push_fire && remove) begin
        count_d = count_q - 1'b1;
      end
      if (err_inc && (err_cnt_q != '1)) begin
        err_cnt_d = err_cnt_q + 1'b1;
      end
    end
    af_d = int'(count_d) >= AF_LEVEL;
    ae_d = int'(count_d) <= AE_LEVEL;
  end

  // Control state register; reset empties the FIFO and clears the counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      err_cnt_q <= '0;
      af_q      <= 1'b0;
      ae_q      <= 1'b1;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      err_cnt_q <= err_cnt_d;
      af_q      <= af_d;
      ae_q      <= ae_d;
    end
  end

  assign count_o        = count_q;
  assign almost_full_o  = af_q;
  assign almost_empty_o = ae_q;
  assign err_cnt_o      = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_chk_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_chk_fifo
// Description : Bench for chk_fifo. Three configurations share one stimulus
//               stream: depth 4 / drop / even, depth 5 / flag / even, and
//               depth 5 / no check / odd. A queue model predicts levels and
//               handshakes; a scoreboard feeds a separate pop monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_chk_fifo;

  localparam int DW = 32;
  localparam int N  = 3;

  typedef logic [DW:0] word_t;
  typedef struct packed {
    word_t w;
    logic  err;
  } exp_t;

  function automatic int cfg_depth(input int i);
    return (i == 0) ? 4 : 5;
  endfunction
  function automatic int cfg_mode(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 2 : 0);
  endfunction
  function automatic int cfg_eo(input int i);
    return (i == 2) ? 1 : 0;
  endfunction
  function automatic int cfg_af(input int i);
    return (i == 1) ? 4 : 3;
  endfunction
  function automatic int cfg_ae(input int i);
    return (i == 2) ? 2 : 1;
  endfunction
  function automatic int cfg_errw(input int i);
    return (i == 0) ? 3 : 8;
  endfunction

  logic  clk   = 1'b0;
  logic  rst   = 1'b1;
  logic  flush = 1'b0;
  logic  pv    = 1'b0;
  logic  pg    = 1'b0;
  word_t pd    = '0;

  logic [N-1:0][DW:0] pop_d;
  logic [N-1:0]       pop_v;
  logic [N-1:0]       pop_e;
  logic [N-1:0]       grant;
  logic [N-1:0]       af;
  logic [N-1:0]       ae;
  logic [N-1:0][2:0]  cnt;
  logic [N-1:0][7:0]  ecnt;

  int    n_cmp  = 0;
  int    n_fail = 0;
  word_t mq [N][$];
  exp_t  sb [N][$];
  int    merr [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int EW = cfg_errw(g);
    logic [EW-1:0] ec;
    chk_fifo_if #(.DATA_WIDTH(DW)) bus ();

    assign bus.push_data_i  = pd;
    assign bus.push_valid_i = pv;
    assign bus.pop_grant_i  = pg;

    chk_fifo #(
      .DATA_WIDTH (DW),
      .FIFO_DEPTH (cfg_depth(g)),
      .EVEN_ODD   (cfg_eo(g)),
      .CHECK_MODE (cfg_mode(g)),
      .AF_LEVEL   (cfg_af(g)),
      .AE_LEVEL   (cfg_ae(g)),
      .ERR_W      (EW)
    ) dut (
      .clk            (clk),
      .rst            (rst),
      .flush_i        (flush),
      .bus            (bus),
      .count_o        (cnt[g]),
      .almost_full_o  (af[g]),
      .almost_empty_o (ae[g]),
      .err_cnt_o      (ec)
    );

    assign ecnt[g]  = 8'(ec);
    assign pop_d[g] = bus.pop_data_o;
    assign pop_v[g] = bus.pop_valid_o;
    assign pop_e[g] = bus.pop_err_o;
    assign grant[g] = bus.push_grant_o;
  end

  task automatic check(input string name, input int d,
                       input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h (t=%0t)", name, d, act, exp, $time);
    end
  endtask

  function automatic logic is_bad(input word_t w, input int eo);
    return ($countones(w) % 2) != eo;
  endfunction

  // Words with correct / wrong even parity.
  function automatic word_t good_w(input logic [31:0] x);
    return {^x, x};
  endfunction
  function automatic word_t bad_w(input logic [31:0] x);
    return {~^x, x};
  endfunction
  function automatic word_t rnd_w();
    logic [31:0] x;
    x = $urandom;
    return ($urandom % 6 == 0) ? bad_w(x) : good_w(x);
  endfunction

  // Reference model: predicts handshakes and levels, loads the scoreboard.
  always @(negedge clk) begin : p_model
    for (int d = 0; d < N; d++) begin
      int    n;
      word_t head;
      logic  bad, e_grant, e_valid, e_err, pop, drop;
      exp_t  e;
      if (rst) begin
        check("grant_in_reset", d, 64'(grant[d]), 64'(0));
        mq[d].delete();
        sb[d].delete();
        merr[d] = 0;
      end else begin
        n       = mq[d].size();
        head    = (n > 0) ? mq[d][0] : '0;
        bad     = (n > 0) && is_bad(head, cfg_eo(d));
        e_grant = (n < cfg_depth(d)) && !flush;
        e_valid = (n > 0) && !(cfg_mode(d) == 1 && bad);
        e_err   = (cfg_mode(d) == 2) && bad;
        check("push_grant",   d, 64'(grant[d]), 64'(e_grant));
        check("pop_valid",    d, 64'(pop_v[d]), 64'(e_valid));
        check("pop_err",      d, 64'(pop_e[d]), 64'(e_err));
        check("count",        d, 64'(cnt[d]),   64'(n));
        check("almost_full",  d, 64'(af[d]),    64'(n >= cfg_af(d)));
        check("almost_empty", d, 64'(ae[d]),    64'(n <= cfg_ae(d)));
        check("err_cnt",      d, 64'(ecnt[d]),  64'(merr[d]));
        if (flush) begin
          mq[d].delete();
          sb[d].delete();
        end else begin
          pop  = e_valid && pg;
          drop = (cfg_mode(d) == 1) && bad;
          if ((drop || (pop && cfg_mode(d) == 2 && bad)) &&
              (merr[d] < (1 << cfg_errw(d)) - 1)) begin
            merr[d]++;
          end
          if (pop || drop) void'(mq[d].pop_front());
          if (pv && e_grant) begin
            mq[d].push_back(pd);
            if (!(cfg_mode(d) == 1 && is_bad(pd, cfg_eo(d)))) begin
              e.w   = pd;
              e.err = (cfg_mode(d) == 2) && is_bad(pd, cfg_eo(d));
              sb[d].push_back(e);
            end
          end
        end
      end
    end
  end

  // Pop monitor: every word the consumer takes must be the next expected one.
  always @(negedge clk) begin : p_mon
    for (int d = 0; d < N; d++) begin
      exp_t e;
      if (!rst && !flush && pop_v[d] && pg) begin
        if (sb[d].size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL pop_unexpected dut%0d: got word 0x%0h, expected no pop", d, pop_d[d]);
        end else begin
          e = sb[d].pop_front();
          check("pop_data",     d, 64'(pop_d[d]), 64'(e.w));
          check("pop_err_word", d, 64'(pop_e[d]), 64'(e.err));
        end
      end
    end
  end

  task automatic drive(input logic v, input word_t data, input logic g, input logic f);
    pv    = v;
    pd    = data;
    pg    = g;
    flush = f;
    @(posedge clk);
    #1;
  endtask

  initial begin : p_stim
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Underflow: pop requests on an empty FIFO.
    repeat (3) drive(1'b0, '0, 1'b1, 1'b0);

    // Overflow: six pushes with no pops, then drain.
    for (int i = 0; i < 6; i++) drive(1'b1, good_w(32'h11 + 32'(i)), 1'b0, 1'b0);
    repeat (6) drive(1'b0, '0, 1'b1, 1'b0);

    // Good / corrupt / good.
    drive(1'b1, good_w(32'h3), 1'b1, 1'b0);
    drive(1'b1, bad_w(32'h3),  1'b1, 1'b0);
    drive(1'b1, good_w(32'h5), 1'b1, 1'b0);
    repeat (5) drive(1'b0, '0, 1'b1, 1'b0);

    // Two pushes per pop opportunity with random consumer stalls.
    for (int i = 0; i < 30; i++) begin
      drive(1'b1, rnd_w(), 1'b0, 1'b0);
      drive(1'b1, rnd_w(), 1'($urandom_range(0, 3) != 0), 1'b0);
    end
    repeat (8) drive(1'b0, '0, 1'b1, 1'b0);

    // Flush with a simultaneous push, then reset mid-stream.
    for (int i = 0; i < 3; i++) drive(1'b1, good_w($urandom), 1'b0, 1'b0);
    drive(1'b1, good_w(32'hDEAD), 1'b0, 1'b1);
    repeat (2) drive(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, rnd_w(), 1'b0, 1'b0);
    rst = 1'b1;
    drive(1'b1, rnd_w(), 1'b1, 1'b0);
    rst = 1'b0;
    repeat (2) drive(1'b0, '0, 1'b1, 1'b0);

    // Fully random traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom % 64 == 0);
      drive(1'($urandom % 4 != 0), rnd_w(), 1'($urandom % 3 != 0), 1'($urandom % 32 == 0));
    end
    rst = 1'b0;
    repeat (10) drive(1'b0, '0, 1'b1, 1'b0);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
